// File: rtl/bcd_cnt_pkg.sv
// Shared types, constants and helpers for the BCD up/down counter.
// Holds the BCD digit type, the largest legal digit and a digit clamp.
package bcd_cnt_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX = 4'd9;

   // Clamp a raw nibble into the legal BCD range (A..F become 9).
   function automatic bcd_digit_t bcd_sanitise(input bcd_digit_t d);
      return (d > BCD_MAX) ? BCD_MAX : d;
   endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// One BCD digit of the counter's increment/decrement ripple chain.
// Ports: d (current digit), up (1=inc, 0=dec), cin (carry/borrow in),
//        q (stepped digit), cout (carry/borrow out to next digit).
module bcd_digit_step
   import bcd_cnt_pkg::*;
(
   input  bcd_digit_t d,
   input  logic       up,
   input  logic       cin,
   output bcd_digit_t q,
   output logic       cout
);

   always_comb begin
      q    = d;
      cout = 1'b0;
      if (cin) begin
         if (up) begin
            if (d >= BCD_MAX) begin
               q    = 4'd0;
               cout = 1'b1;
            end else begin
               q = d + 4'd1;
            end
         end else begin
            if (d == 4'd0) begin
               q    = BCD_MAX;
               cout = 1'b1;
            end else begin
               q = d - 4'd1;
            end
         end
      end
   end

endmodule

// File: rtl/bcd_updown_counter_n.sv
// NUM_DIGITS-digit BCD up/down counter with wrap/saturate and a limit.
// Ports: clk_out, rst_n (async low), en, dir, sat, clr, limit,
//        load/load_val (only with BCD_CNT_PRESET_EN), digits, tc.
module bcd_updown_counter_n
   import bcd_cnt_pkg::*;
#(
   parameter int NUM_DIGITS = 4
) (
   input  logic                    clk_out,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    dir,
   input  logic                    sat,
   input  logic                    clr,
   input  logic [4*NUM_DIGITS-1:0] limit,
`ifdef BCD_CNT_PRESET_EN
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] load_val,
`endif
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic                    tc
);

   localparam int W = 4 * NUM_DIGITS;

   logic [W-1:0]        lim_s;
   logic [W-1:0]        load_s;
   logic                do_load;
   logic [W-1:0]        stepped;
   logic [NUM_DIGITS:0] carry;
   logic                unused_cout;
   logic                at_lim;
   logic                at_zero;
   logic                above;
   logic                decided;
   logic [W-1:0]        digits_d;
   logic                tc_d;

`ifdef BCD_CNT_PRESET_EN
   assign do_load = load;
   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_load
      assign load_s[4*i +: 4] = bcd_sanitise(load_val[4*i +: 4]);
   end
`else
   assign do_load = 1'b0;
   assign load_s  = '0;
`endif

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lim
      assign lim_s[4*i +: 4] = bcd_sanitise(limit[4*i +: 4]);
   end

   // Units digit always steps; higher digits step on carry/borrow.
   assign carry[0] = 1'b1;

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
      bcd_digit_step u_step (
         .d    (digits[4*i +: 4]),
         .up   (dir),
         .cin  (carry[i]),
         .q    (stepped[4*i +: 4]),
         .cout (carry[i+1])
      );
   end

   // Overflow out of the top digit is covered by the limit checks.
   assign unused_cout = carry[NUM_DIGITS];

   assign at_lim  = (digits == lim_s);
   assign at_zero = (digits == '0);

   // Magnitude compare, most-significant digit first.
   always_comb begin
      above   = 1'b0;
      decided = 1'b0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         if (!decided && (digits[4*i +: 4] != lim_s[4*i +: 4])) begin
            decided = 1'b1;
            above   = (digits[4*i +: 4] > lim_s[4*i +: 4]);
         end
      end
   end

   always_comb begin
      digits_d = digits;
      tc_d     = 1'b0;
      if (clr) begin
         digits_d = '0;
      end else if (do_load) begin
         digits_d = load_s;
      end else if (en) begin
         if (dir) begin
            if (above) begin
               digits_d = '0;
            end else if (at_lim) begin
               tc_d = 1'b1;
               if (!sat) digits_d = '0;
            end else begin
               digits_d = stepped;
            end
         end else begin
            if (above) begin
               digits_d = lim_s;
            end else if (at_zero) begin
               tc_d = 1'b1;
               if (!sat) digits_d = lim_s;
            end else begin
               digits_d = stepped;
            end
         end
      end
   end

   always_ff @(posedge clk_out or negedge rst_n) begin
      if (!rst_n) begin
         digits <= '0;
         tc     <= 1'b0;
      end else begin
         digits <= digits_d;
         tc     <= tc_d;
      end
   end

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Bench for bcd_updown_counter_n (2 digits): integer model + literals.
// Covers wrap, saturate, limit lowering, sanitise, preset and async reset.
module tb_bcd_updown_counter_n;

   localparam int ND = 2;
   localparam int W  = 4 * ND;

   logic         clk_out = 1'b0;
   logic         rst_n   = 1'b0;
   logic         en      = 1'b0;
   logic         dir     = 1'b0;
   logic         sat     = 1'b0;
   logic         clr     = 1'b0;
   logic [W-1:0] limit   = 8'h59;
   logic         load    = 1'b0;
   logic [W-1:0] load_val = '0;
   logic [W-1:0] digits;
   logic         tc;

   int n_tests = 0;
   int n_fail  = 0;

   bcd_updown_counter_n #(.NUM_DIGITS(ND)) dut (
      .clk_out  (clk_out),
      .rst_n    (rst_n),
      .en       (en),
      .dir      (dir),
      .sat      (sat),
      .clr      (clr),
      .limit    (limit),
`ifdef BCD_CNT_PRESET_EN
      .load     (load),
      .load_val (load_val),
`endif
      .digits   (digits),
      .tc       (tc)
   );

   always #5 clk_out = ~clk_out;

`ifdef BCD_CNT_PRESET_EN
   localparam bit HAS_LOAD = 1'b1;
`else
   localparam bit HAS_LOAD = 1'b0;
`endif

   // Model: plain decimal integer, converted to BCD only for comparison.
   int m_cnt = 0;
   bit m_tc  = 1'b0;

   function automatic int bcd_to_int(input logic [W-1:0] v);
      int r = 0;
      int d;
      for (int i = ND - 1; i >= 0; i--) begin
         d = int'(v[4*i +: 4]);
         if (d > 9) d = 9;
         r = r * 10 + d;
      end
      return r;
   endfunction

   function automatic logic [W-1:0] int_to_bcd(input int v);
      logic [W-1:0] r = '0;
      int x = v;
      for (int i = 0; i < ND; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   always @(posedge clk_out or negedge rst_n) begin
      int lim;
      if (!rst_n) begin
         m_cnt = 0;
         m_tc  = 1'b0;
      end else begin
         lim  = bcd_to_int(limit);
         m_tc = 1'b0;
         if (clr) begin
            m_cnt = 0;
         end else if (HAS_LOAD && load) begin
            m_cnt = bcd_to_int(load_val);
         end else if (en) begin
            if (dir) begin
               if (m_cnt > lim) m_cnt = 0;
               else if (m_cnt == lim) begin
                  m_tc = 1'b1;
                  if (!sat) m_cnt = 0;
               end else m_cnt = m_cnt + 1;
            end else begin
               if (m_cnt > lim) m_cnt = lim;
               else if (m_cnt == 0) begin
                  m_tc = 1'b1;
                  if (!sat) m_cnt = lim;
               end else m_cnt = m_cnt - 1;
            end
         end
      end
   end

   always @(negedge clk_out) begin
      if (rst_n) begin
         n_tests++;
         if (digits !== int_to_bcd(m_cnt)) begin
            n_fail++;
            $display("FAIL model_digits t=%0t got %h exp %h",
                     $time, digits, int_to_bcd(m_cnt));
         end
         n_tests++;
         if (tc !== m_tc) begin
            n_fail++;
            $display("FAIL model_tc t=%0t got %b exp %b",
                     $time, tc, m_tc);
         end
      end
   end

   task automatic lit(input string name, input logic [W-1:0] exp_d,
                      input logic exp_tc);
      n_tests++;
      if (digits !== exp_d || tc !== exp_tc) begin
         n_fail++;
         $display("FAIL %s got digits=%h tc=%b exp digits=%h tc=%b",
                  name, digits, tc, exp_d, exp_tc);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk_out);
   endtask

   task automatic do_clr();
      en  = 1'b0;
      clr = 1'b1;
      cyc(1);
      clr = 1'b0;
   endtask

   initial begin
      #3;
      lit("reset_state", 8'h00, 1'b0);
      cyc(1);
      rst_n = 1'b1;
      lit("after_reset", 8'h00, 1'b0);

      // Up count with wrap at 59.
      en = 1'b1; dir = 1'b1; sat = 1'b0;
      cyc(1);
      lit("up_first", 8'h01, 1'b0);
      cyc(58);
      lit("up_59", 8'h59, 1'b0);
      cyc(1);
      lit("up_wrap", 8'h00, 1'b1);
      cyc(1);
      lit("up_after_wrap", 8'h01, 1'b0);

      // Down from 00 wraps to limit.
      do_clr();
      lit("clr", 8'h00, 1'b0);
      en = 1'b1; dir = 1'b0;
      cyc(1);
      lit("down_wrap", 8'h59, 1'b1);
      cyc(1);
      lit("down_58", 8'h58, 1'b0);

      // Hold with en low.
      en = 1'b0;
      cyc(3);
      lit("hold", 8'h58, 1'b0);

      // Saturate up.
      en = 1'b1; dir = 1'b1; sat = 1'b1;
      cyc(1);
      lit("sat_up_59", 8'h59, 1'b0);
      cyc(1);
      lit("sat_up_hold1", 8'h59, 1'b1);
      cyc(1);
      lit("sat_up_hold2", 8'h59, 1'b1);

      // Saturate down.
      do_clr();
      en = 1'b1; dir = 1'b0; sat = 1'b1;
      cyc(1);
      lit("sat_dn_hold1", 8'h00, 1'b1);
      cyc(1);
      lit("sat_dn_hold2", 8'h00, 1'b1);

      // Limit lowered below count, up.
      do_clr();
      en = 1'b1; dir = 1'b1; sat = 1'b0;
      cyc(45);
      lit("reach_45", 8'h45, 1'b0);
      limit = 8'h30;
      cyc(1);
      lit("above_up", 8'h00, 1'b0);

      // Limit lowered below count, down.
      limit = 8'h59;
      do_clr();
      en = 1'b1; dir = 1'b1;
      cyc(45);
      limit = 8'h30; dir = 1'b0; sat = 1'b1;
      cyc(1);
      lit("above_dn", 8'h30, 1'b0);

      // Non-BCD limit digits clamp to 9.
      do_clr();
      limit = 8'hAB; sat = 1'b0; en = 1'b1; dir = 1'b0;
      cyc(1);
      lit("sanitise_lim", 8'h99, 1'b1);
      dir = 1'b1;
      cyc(1);
      lit("wrap_99", 8'h00, 1'b1);
      limit = 8'h59;

`ifdef BCD_CNT_PRESET_EN
      en = 1'b1; dir = 1'b1;
      load = 1'b1; load_val = 8'h7C; limit = 8'h99;
      cyc(1);
      lit("load_7C", 8'h79, 1'b0);
      load = 1'b0;
      cyc(1);
      lit("after_load", 8'h80, 1'b0);
      load = 1'b1; clr = 1'b1;
      cyc(1);
      lit("clr_over_load", 8'h00, 1'b0);
      load = 1'b0; clr = 1'b0;
      limit = 8'h59;
`endif

      // Async reset mid-count.
      do_clr();
      en = 1'b1; dir = 1'b1; sat = 1'b0;
      cyc(37);
      lit("reach_37", 8'h37, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      lit("async_rst", 8'h00, 1'b0);
      cyc(1);
      lit("rst_held", 8'h00, 1'b0);
      rst_n = 1'b1;
      cyc(1);
      lit("restart", 8'h01, 1'b0);
      cyc(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
